// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop.
// Presents each byte with a one-cycle valid strobe and error flags.
module uart_rx #(
    parameter int CLK_FREQ  = 6000000,
    parameter int BAUD_RATE = 600000,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic ODD        = (PARITY != 0);
    localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            armed_q, armed_d;
    logic            meta_q, rx_s_q;
    logic [1:0]      sync_ok_q;
    logic            exp_par;

    // sync_ok_q masks the synchroniser's reset value so that a line
    // already low at reset release is not mistaken for a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            sync_ok_q <= 2'b00;
        end else begin
            meta_q    <= rx;
            rx_s_q    <= meta_q;
            sync_ok_q <= {sync_ok_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    assign exp_par = (^shift_q) ^ ODD;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (sync_ok_q[1] && rx_s_q) armed_d = 1'b1;
                if (armed_q && !rx_s_q) state_d = START;
            end
            START: begin
                if (timer_q == HALF_END) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PAR;
                end
            end
            PAR: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = (par_q != exp_par);
                    ferr_d  = !rx_s_q;
                    state_d = rx_s_q ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                timer_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_rx    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign rx_busy    = (state_q == START) || (state_q == DATA) ||
                        (state_q == PAR)   || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: even-parity main instance plus an
// odd-parity instance used for the parity-polarity case.
module tb_uart_rx;

    localparam int CPB = 10;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx, rx_o;
    logic [7:0] data_rx, data_o;
    logic       rx_valid, o_valid;
    logic       parity_err, perr_o;
    logic       frame_err, ferr_o;
    logic       rx_busy, busy_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   vcount = 0;
    int   vcount_o = 0;
    logic prev_valid = 1'b0;
    logic busy_seen = 1'b0;
    exp_t exp_q[$];
    int   vtimes[$];

    uart_rx u_dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_rx    (data_rx),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    uart_rx #(.PARITY(1)) u_odd (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_o),
        .data_rx    (data_o),
        .rx_valid   (o_valid),
        .parity_err (perr_o),
        .frame_err  (ferr_o),
        .rx_busy    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_busy) busy_seen = 1'b1;
        if (o_valid) vcount_o++;
        if (rx_valid) begin
            exp_t e;
            vcount++;
            vtimes.push_back(cyc);
            if (prev_valid) check("valid_width", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", 32'(data_rx), 32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.pe));
                check("frame_err", 32'(frame_err), 32'(e.fe));
                check("busy_at_valid", 32'(rx_busy), 0);
            end
        end
        prev_valid = rx_valid;
    end

    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic stop, input bit odd_line);
        logic [10:0] bits;
        bits = {stop, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (odd_line) rx_o = bits[i];
            else rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pbit,
                                input logic stop);
        exp_t e;
        e.d  = d;
        e.pe = (pbit != (^d));
        e.fe = !stop;
        exp_q.push_back(e);
    endtask

    task automatic good_frame(input logic [7:0] d);
        expect_frame(d, ^d, 1'b1);
        send_frame(d, ^d, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v0;
        logic [7:0] d0;
        logic pe0, fe0;

        reset = 1'b1;
        rx    = 1'b1;
        rx_o  = 1'b1;
        idle(3);
        check("rst_data", 32'(data_rx), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_perr", 32'(parity_err), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_busy", 32'(rx_busy), 0);
        reset = 1'b0;
        idle(6);

        // Ideal 0xA5 frame
        good_frame(8'hA5);
        idle(3);
        check("a5_busy_after", 32'(rx_busy), 0);
        check("a5_drained", exp_q.size(), 0);

        // Parity error: 0x01 with parity bit 0 on even receiver
        expect_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        idle(5);
        check("par_drained", exp_q.size(), 0);

        // Same frame on the odd-parity receiver
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        idle(5);
        check("odd_count", vcount_o, 1);
        check("odd_data", 32'(data_o), 32'h01);
        check("odd_perr", 32'(perr_o), 0);
        check("odd_ferr", 32'(ferr_o), 0);

        // Break: stop bit 0, line held low, then clean frame
        v0 = vcount;
        expect_frame(8'h3C, ^8'h3C, 1'b0);
        send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        idle(50);
        check("brk_busy_low", 32'(rx_busy), 0);
        rx = 1'b1;
        idle(20);
        check("brk_count", vcount - v0, 1);
        good_frame(8'h42);
        idle(5);
        check("brk_drained", exp_q.size(), 0);

        // Glitch on idle line
        v0 = vcount;
        d0 = data_rx;
        pe0 = parity_err;
        fe0 = frame_err;
        busy_seen = 1'b0;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check("gl_busy_seen", 32'(busy_seen), 1);
        check("gl_busy_end", 32'(rx_busy), 0);
        check("gl_count", vcount - v0, 0);
        check("gl_data", 32'(data_rx), 32'(d0));
        check("gl_perr", 32'(parity_err), 32'(pe0));
        check("gl_ferr", 32'(frame_err), 32'(fe0));

        // Back-to-back frames
        v0 = vtimes.size();
        good_frame(8'h55);
        good_frame(8'hAA);
        idle(10);
        check("b2b_count", vtimes.size() - v0, 2);
        if (vtimes.size() - v0 == 2)
            check("b2b_spacing", vtimes[v0+1] - vtimes[v0], 110);

        // Reset in the middle of data bit 4 of an all-zero frame
        v0 = vcount;
        fork
            send_frame(8'h00, 1'b0, 1'b1, 1'b0);
            begin
                idle(55);
                reset = 1'b1;
                idle(3);
                reset = 1'b0;
                #1;
                check("ab_data", 32'(data_rx), 0);
                check("ab_valid", 32'(rx_valid), 0);
                check("ab_perr", 32'(parity_err), 0);
                check("ab_ferr", 32'(frame_err), 0);
                check("ab_busy", 32'(rx_busy), 0);
            end
        join
        idle(20);
        check("ab_count", vcount - v0, 0);
        check("ab_busy_idle", 32'(rx_busy), 0);
        good_frame(8'h81);
        idle(10);
        check("ab_next_count", vcount - v0, 1);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
